// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - per-frame sprite mover with edge bounce, or edge wrap when SPRITE_WRAP_EN is defined
module sprite_motion_ctrl #(
    parameter int WIDTH    = 128,
    parameter int HEIGHT   = 128,
    parameter int NUM_IMGS = 4,
    parameter int SCREEN_W = 1280,
    parameter int SCREEN_H = 720,
    parameter int X_INIT   = 0,
    parameter int Y_INIT   = 0
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        new_frame_in,
    input  logic [3:0]  speed_in,
    input  logic        pause_in,
    input  logic        shape_next_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [1:0]  shape_out,
    output logic        bounce_out
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] UPD_X  = 2'd1;
    localparam logic [1:0] UPD_Y  = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    localparam logic [11:0] X_MAX = 12'(SCREEN_W - WIDTH);
    localparam logic [11:0] Y_MAX = 12'(SCREEN_H - HEIGHT);
    localparam logic [1:0]  SHAPE_LAST = 2'(NUM_IMGS - 1);

    logic [1:0]  state_q, state_d;
    logic [10:0] x_q, x_d, nx_q, nx_d;
    logic [9:0]  y_q, y_d, ny_q, ny_d;
    logic [1:0]  shape_q, shape_d;
    logic        bounce_q, bounce_d;
    logic        dir_x_q, dir_x_d, ndir_x_q, ndir_x_d;
    logic        dir_y_q, dir_y_d, ndir_y_q, ndir_y_d;
    logic        bx_q, bx_d, by_q, by_d;
    logic        pending_q, pending_d;
    logic [3:0]  speed_q, speed_d;
    logic        pause_q, pause_d;

    logic [11:0] x_ext, y_ext, spd_ext, x_sum, y_sum;
    logic [10:0] nx_c;
    logic [9:0]  ny_c;
    logic        ndx_c, ndy_c, bx_c, by_c;

    assign x_ext   = {1'b0, x_q};
    assign y_ext   = {2'b0, y_q};
    assign spd_ext = {8'b0, speed_q};
    assign x_sum   = x_ext + spd_ext;
    assign y_sum   = y_ext + spd_ext;

    // Candidate positions; dir 1 means moving toward larger coordinates.
    always_comb begin
        nx_c  = x_q;
        ny_c  = y_q;
        ndx_c = dir_x_q;
        ndy_c = dir_y_q;
        bx_c  = 1'b0;
        by_c  = 1'b0;
        if (!pause_q && speed_q != 4'd0) begin
`ifdef SPRITE_WRAP_EN
            if (x_sum > X_MAX) begin
                nx_c = 11'(x_sum - X_MAX - 12'd1);
                bx_c = 1'b1;
            end else begin
                nx_c = x_sum[10:0];
            end
            if (y_sum > Y_MAX) begin
                ny_c = 10'(y_sum - Y_MAX - 12'd1);
                by_c = 1'b1;
            end else begin
                ny_c = y_sum[9:0];
            end
`else
            if (dir_x_q) begin
                if (x_sum >= X_MAX) begin
                    nx_c = X_MAX[10:0]; ndx_c = 1'b0; bx_c = 1'b1;
                end else begin
                    nx_c = x_sum[10:0];
                end
            end else if (x_ext <= spd_ext) begin
                nx_c = 11'd0; ndx_c = 1'b1; bx_c = 1'b1;
            end else begin
                nx_c = 11'(x_ext - spd_ext);
            end
            if (dir_y_q) begin
                if (y_sum >= Y_MAX) begin
                    ny_c = Y_MAX[9:0]; ndy_c = 1'b0; by_c = 1'b1;
                end else begin
                    ny_c = y_sum[9:0];
                end
            end else if (y_ext <= spd_ext) begin
                ny_c = 10'd0; ndy_c = 1'b1; by_c = 1'b1;
            end else begin
                ny_c = 10'(y_ext - spd_ext);
            end
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        shape_d  = shape_q;
        bounce_d = 1'b0;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        ndir_x_d = ndir_x_q;
        ndir_y_d = ndir_y_q;
        bx_d     = bx_q;
        by_d     = by_q;
        speed_d  = speed_q;
        pause_d  = pause_q;
        // A strobe landing on the commit cycle must survive the clear.
        pending_d = (state_q == COMMIT) ? shape_next_in : (pending_q | shape_next_in);
        case (state_q)
            IDLE: begin
                if (new_frame_in) begin
                    speed_d = speed_in;
                    pause_d = pause_in;
                    state_d = UPD_X;
                end
            end
            UPD_X: begin
                nx_d     = nx_c;
                ndir_x_d = ndx_c;
                bx_d     = bx_c;
                state_d  = UPD_Y;
            end
            UPD_Y: begin
                ny_d     = ny_c;
                ndir_y_d = ndy_c;
                by_d     = by_c;
                state_d  = COMMIT;
            end
            COMMIT: begin
                x_d      = nx_q;
                y_d      = ny_q;
                dir_x_d  = ndir_x_q;
                dir_y_d  = ndir_y_q;
                bounce_d = bx_q | by_q;
                if (pending_q) begin
                    shape_d = (shape_q == SHAPE_LAST) ? 2'd0 : shape_q + 2'd1;
                end
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            x_q       <= 11'(X_INIT);
            y_q       <= 10'(Y_INIT);
            nx_q      <= 11'(X_INIT);
            ny_q      <= 10'(Y_INIT);
            shape_q   <= 2'd0;
            bounce_q  <= 1'b0;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            ndir_x_q  <= 1'b1;
            ndir_y_q  <= 1'b1;
            bx_q      <= 1'b0;
            by_q      <= 1'b0;
            pending_q <= 1'b0;
            speed_q   <= 4'd0;
            pause_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            nx_q      <= nx_d;
            ny_q      <= ny_d;
            shape_q   <= shape_d;
            bounce_q  <= bounce_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            ndir_x_q  <= ndir_x_d;
            ndir_y_q  <= ndir_y_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            pending_q <= pending_d;
            speed_q   <= speed_d;
            pause_q   <= pause_d;
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign shape_out  = shape_q;
    assign bounce_out = bounce_q;
endmodule
